// File: rtl/program_runner.sv
// Test sequencer: loads a program into instruction memory, runs the CPU until it halts
// (jump-to-self) or times out, then checks one data-memory word against an expected value.
`timescale 1ns/1ps
module program_runner #(
    parameter int unsigned IMEM_AW     = 6,
    parameter int unsigned CYC_W       = 16,
    parameter int unsigned MAX_CYCLES  = 1000,
    parameter int unsigned HALT_REPEAT = 2
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               start,
    input  logic               ld_valid,
    input  logic [31:0]        ld_data,
    input  logic               ld_last,
    output logic               ld_ready,
    output logic               imem_we,
    output logic [IMEM_AW-1:0] imem_addr,
    output logic [31:0]        imem_wdata,
    output logic               cpu_rst_n,
    input  logic [31:0]        cpu_pc,
    input  logic [31:0]        chk_addr,
    input  logic [31:0]        chk_expect,
    output logic [31:0]        dmem_raddr,
    input  logic [31:0]        dmem_rdata,
    output logic               busy,
    output logic               done,
    output logic               pass,
    output logic               timeout,
    output logic [CYC_W-1:0]   cycles
);

    typedef enum logic [2:0] {StIdle, StLoad, StRun, StCheck, StDone} state_e;

    localparam logic [CYC_W-1:0]   MaxCycM1 = CYC_W'(MAX_CYCLES - 1);
    localparam logic [CYC_W-1:0]   HaltM1   = CYC_W'(HALT_REPEAT - 1);
    localparam logic [IMEM_AW-1:0] LastIdx  = '1;

    state_e             st_q, st_d;
    logic [IMEM_AW-1:0] idx_q, idx_d;
    logic [CYC_W-1:0]   cycles_q, cycles_d;
    logic [CYC_W-1:0]   run_cnt_q, run_cnt_d;
    logic [31:0]        prev_pc_q, prev_pc_d;
    logic               prev_valid_q, prev_valid_d;
    logic [31:0]        chk_addr_q, chk_addr_d;
    logic [31:0]        chk_expect_q, chk_expect_d;
    logic               pass_q, pass_d;
    logic               timeout_q, timeout_d;

    logic [CYC_W-1:0]   run_inc;
    logic               pc_same;
    logic               halt;

    assign run_inc = run_cnt_q + CYC_W'(1);
    // prev_valid_q keeps the first RUN cycle from ever looking like a halt
    assign pc_same = prev_valid_q && (cpu_pc == prev_pc_q);
    assign halt    = pc_same && (run_inc >= HaltM1);

    always_comb begin
        st_d         = st_q;
        idx_d        = idx_q;
        cycles_d     = cycles_q;
        run_cnt_d    = run_cnt_q;
        prev_pc_d    = prev_pc_q;
        prev_valid_d = prev_valid_q;
        chk_addr_d   = chk_addr_q;
        chk_expect_d = chk_expect_q;
        pass_d       = pass_q;
        timeout_d    = timeout_q;
        case (st_q)
            StIdle, StDone: begin
                if (start) begin
                    st_d         = StLoad;
                    idx_d        = '0;
                    cycles_d     = '0;
                    pass_d       = 1'b0;
                    timeout_d    = 1'b0;
                    chk_addr_d   = chk_addr;
                    chk_expect_d = chk_expect;
                end
            end
            StLoad: begin
                if (ld_valid) begin
                    idx_d = idx_q + IMEM_AW'(1);
                    if (ld_last || idx_q == LastIdx) begin
                        st_d         = StRun;
                        run_cnt_d    = '0;
                        prev_valid_d = 1'b0;
                    end
                end
            end
            StRun: begin
                cycles_d     = (cycles_q == '1) ? cycles_q : cycles_q + CYC_W'(1);
                prev_pc_d    = cpu_pc;
                prev_valid_d = 1'b1;
                run_cnt_d    = pc_same ? run_inc : '0;
                if (halt) begin
                    st_d = StCheck;
                end else if (cycles_q >= MaxCycM1) begin
                    st_d      = StDone;
                    timeout_d = 1'b1;
                    pass_d    = 1'b0;
                end
            end
            StCheck: begin
                pass_d = (dmem_rdata == chk_expect_q);
                st_d   = StDone;
            end
            default: st_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            st_q         <= StIdle;
            idx_q        <= '0;
            cycles_q     <= '0;
            run_cnt_q    <= '0;
            prev_pc_q    <= '0;
            prev_valid_q <= 1'b0;
            chk_addr_q   <= '0;
            chk_expect_q <= '0;
            pass_q       <= 1'b0;
            timeout_q    <= 1'b0;
        end else begin
            st_q         <= st_d;
            idx_q        <= idx_d;
            cycles_q     <= cycles_d;
            run_cnt_q    <= run_cnt_d;
            prev_pc_q    <= prev_pc_d;
            prev_valid_q <= prev_valid_d;
            chk_addr_q   <= chk_addr_d;
            chk_expect_q <= chk_expect_d;
            pass_q       <= pass_d;
            timeout_q    <= timeout_d;
        end
    end

    assign ld_ready   = (st_q == StLoad);
    assign imem_we    = ld_ready && ld_valid;
    assign imem_addr  = idx_q;
    assign imem_wdata = ld_data;
    assign cpu_rst_n  = (st_q == StRun);
    assign dmem_raddr = chk_addr_q;
    assign busy       = (st_q == StLoad) || (st_q == StRun) || (st_q == StCheck);
    assign done       = (st_q == StDone);
    assign pass       = pass_q;
    assign timeout    = timeout_q;
    assign cycles     = cycles_q;

endmodule

// File: tb/tb_program_runner.sv
// Bench for program_runner: a toy CPU/memory environment plus an instruction-level model
// that predicts run length, halt/timeout and the checked word, compared every cycle.
`timescale 1ns/1ps
module tb_program_runner;

    localparam int MAXC = 1000;
    localparam int PIDLE = 0, PLOAD = 1, PRUN = 2, PCHECK = 3, PDONE = 4;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0;
    logic        ld_valid = 1'b0;
    logic [31:0] ld_data = '0;
    logic        ld_last = 1'b0;
    logic        ld_ready, imem_we, cpu_rst_n, busy, done, pass, timeout;
    logic [5:0]  imem_addr;
    logic [31:0] imem_wdata, cpu_pc, dmem_raddr, dmem_rdata;
    logic [31:0] chk_addr = '0;
    logic [31:0] chk_expect = '0;
    logic [15:0] cycles;
    logic        env_clr = 1'b0;
    bit          chk_on = 1'b0;

    int n_tests = 0;
    int n_fail = 0;

    program_runner dut (
        .clk(clk), .reset_n(reset_n), .start(start), .ld_valid(ld_valid), .ld_data(ld_data),
        .ld_last(ld_last), .ld_ready(ld_ready), .imem_we(imem_we), .imem_addr(imem_addr),
        .imem_wdata(imem_wdata), .cpu_rst_n(cpu_rst_n), .cpu_pc(cpu_pc), .chk_addr(chk_addr),
        .chk_expect(chk_expect), .dmem_raddr(dmem_raddr), .dmem_rdata(dmem_rdata),
        .busy(busy), .done(done), .pass(pass), .timeout(timeout), .cycles(cycles)
    );

    always #5 clk = ~clk;

    // Toy ISA: [31:30]=01 store imm16 to dmem word [21:16]; =10 jump to word [5:0]; else nop.
    logic [31:0] t_imem [64];
    logic [31:0] t_dmem [64];
    logic [31:0] pc_r = '0;
    logic [31:0] cur_ins;
    assign cur_ins    = t_imem[pc_r[7:2]];
    assign cpu_pc     = pc_r;
    assign dmem_rdata = t_dmem[dmem_raddr[7:2]];

    always @(posedge clk) begin
        if (env_clr) begin
            for (int i = 0; i < 64; i++) begin
                t_imem[i] <= '0;
                t_dmem[i] <= '0;
            end
        end
        if (imem_we) t_imem[imem_addr] <= imem_wdata;
        if (cpu_rst_n !== 1'b1) begin
            pc_r <= '0;
        end else begin
            if (cur_ins[31:30] == 2'b01) t_dmem[cur_ins[21:16]] <= {16'h0, cur_ins[15:0]};
            pc_r <= (cur_ins[31:30] == 2'b10) ? {24'h0, cur_ins[5:0], 2'b00}
                                              : {24'h0, pc_r[7:0] + 8'd4};
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            if (n_fail <= 40) $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [31:0] m_prog [64];
    int          m_phase = PIDLE;
    int          m_idx = 0;
    int          m_run = 0;
    bit          m_pass = 1'b0;
    bit          m_tout = 1'b0;
    logic [31:0] m_addr = '0;
    logic [31:0] m_expect = '0;
    logic [63:0] m_res = '0;
    logic [31:0] m_word;
    bit          m_halted;
    int          m_len;
    assign m_word   = m_res[63:32];
    assign m_halted = m_res[31];
    assign m_len    = int'(m_res[30:0]);

    // Executes the program instruction by instruction: RUN length, halt flag, checked word.
    function automatic logic [63:0] simulate(input int wi, input logic [31:0] wd, input int ri);
        logic [31:0] prog [64];
        logic [31:0] dm [64];
        logic [7:0]  pc, prev;
        logic [31:0] ins;
        int          len;
        bit          halted;
        for (int i = 0; i < 64; i++) begin
            prog[i] = m_prog[i];
            dm[i]   = '0;
        end
        prog[wi] = wd;
        pc = '0; prev = '0; halted = 1'b0; len = MAXC;
        for (int k = 0; k < MAXC; k++) begin
            if (k >= 1 && pc == prev) begin
                halted = 1'b1;
                len    = k + 1;
            end
            ins = prog[pc[7:2]];
            if (ins[31:30] == 2'b01) dm[ins[21:16]] = {16'h0, ins[15:0]};
            prev = pc;
            pc   = (ins[31:30] == 2'b10) ? {ins[5:0], 2'b00} : pc + 8'd4;
            if (halted) break;
        end
        return {dm[ri], halted, 31'(len)};
    endfunction

    always @(posedge clk) begin
        if (env_clr) for (int i = 0; i < 64; i++) m_prog[i] <= '0;
        if (!reset_n) begin
            m_phase <= PIDLE; m_idx <= 0; m_run <= 0; m_pass <= 1'b0; m_tout <= 1'b0;
            m_addr <= '0; m_expect <= '0;
        end else begin
            case (m_phase)
                PIDLE, PDONE: if (start) begin
                    m_phase <= PLOAD; m_idx <= 0; m_run <= 0; m_pass <= 1'b0; m_tout <= 1'b0;
                    m_addr <= chk_addr; m_expect <= chk_expect;
                end
                PLOAD: if (ld_valid) begin
                    m_prog[m_idx] <= ld_data;
                    m_idx <= m_idx + 1;
                    if (ld_last || m_idx == 63) begin
                        m_phase <= PRUN;
                        m_res <= simulate(m_idx, ld_data, int'(m_addr[7:2]));
                    end
                end
                PRUN: begin
                    m_run <= m_run + 1;
                    if (m_run + 1 == m_len) begin
                        if (m_halted) m_phase <= PCHECK;
                        else begin
                            m_phase <= PDONE;
                            m_tout  <= 1'b1;
                        end
                    end
                end
                PCHECK: begin
                    m_pass  <= (m_word == m_expect);
                    m_phase <= PDONE;
                end
                default: m_phase <= PIDLE;
            endcase
        end
    end

    always @(negedge clk) begin
        if (chk_on) begin
            check("busy", 32'(busy), 32'(m_phase == PLOAD || m_phase == PRUN || m_phase == PCHECK));
            check("done", 32'(done), 32'(m_phase == PDONE));
            check("ld_ready", 32'(ld_ready), 32'(m_phase == PLOAD));
            check("cpu_rst_n", 32'(cpu_rst_n), 32'(m_phase == PRUN));
            check("imem_we", 32'(imem_we), 32'(m_phase == PLOAD && ld_valid));
            if (m_phase == PLOAD && ld_valid) begin
                check("imem_addr", 32'(imem_addr), 32'(m_idx));
                check("imem_wdata", imem_wdata, ld_data);
            end
            check("cycles", 32'(cycles), 32'(m_run));
            check("pass", 32'(pass), 32'(m_pass));
            check("timeout", 32'(timeout), 32'(m_tout));
            if (m_phase == PCHECK) check("dmem_raddr", dmem_raddr, m_addr);
        end
    end

    // ---------------- stimulus ----------------
    logic [31:0] s_prog [64];
    int          s_n;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_word(input logic [31:0] w, input bit last);
        int guard = 0;
        ld_data = w; ld_last = last; ld_valid = 1'b1;
        @(negedge clk);
        while (!ld_ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        if (!ld_ready) check("ld_handshake_wait", 32'(ld_ready), 32'd1);
        tick();
        ld_valid = 1'b0; ld_last = 1'b0;
    endtask

    task automatic run_test(input logic [31:0] addr, input logic [31:0] expv, input int gap,
                            input bit use_last);
        env_clr = 1'b1;
        tick();
        env_clr = 1'b0;
        chk_addr = addr; chk_expect = expv; start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < s_n; i++) begin
            repeat (gap) tick();
            send_word(s_prog[i], use_last && (i == s_n - 1));
        end
    endtask

    task automatic wait_done(input int budget, output int waited);
        waited = 0;
        while (!done && waited < budget) begin
            @(negedge clk);
            waited++;
        end
        check("done_within_budget", 32'(done), 32'd1);
    endtask

    initial begin
        int w;
        int mism;
        repeat (2) tick();
        chk_on = 1'b1;
        tick();
        reset_n = 1'b1;
        @(negedge clk);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_cpu_rst_n", 32'(cpu_rst_n), 32'd0);
        check("rst_cycles", 32'(cycles), 32'd0);
        check("rst_dmem_raddr", dmem_raddr, 32'd0);
        check("rst_imem_addr", 32'(imem_addr), 32'd0);

        // nop (addi stand-in), store 0xFEFE to word 0, jump to self
        for (int i = 0; i < 64; i++) s_prog[i] = '0;
        s_prog[1] = 32'h4000_FEFE;
        s_prog[2] = 32'h8000_0002;
        s_n = 3;
        run_test(32'h0, 32'h0000_FEFE, 0, 1'b1);
        wait_done(10, w);
        check("t1_pass", 32'(pass), 32'd1);
        check("t1_timeout", 32'(timeout), 32'd0);
        check("t1_cycles", 32'(cycles), 32'd4);
        for (int i = 0; i < 3; i++) check("t1_imem_word", t_imem[i], s_prog[i]);

        run_test(32'h0, 32'h0000_1234, 1, 1'b1);
        wait_done(20, w);
        check("t2_pass", 32'(pass), 32'd0);
        check("t2_timeout", 32'(timeout), 32'd0);

        for (int i = 0; i < 64; i++) s_prog[i] = '0;
        s_n = 5;
        run_test(32'h0, 32'h0, 0, 1'b1);
        wait_done(MAXC + 20, w);
        check("t3_timeout", 32'(timeout), 32'd1);
        check("t3_pass", 32'(pass), 32'd0);
        check("t3_cycles", 32'(cycles), 32'(MAXC));

        // full memory, no ld_last, ld_valid every other cycle
        for (int i = 0; i < 63; i++) s_prog[i] = 32'h0000_1100 + 32'(i);
        s_prog[63] = 32'h8000_003F;
        s_n = 64;
        run_test(32'h4, 32'h0, 1, 1'b0);
        ld_valid = 1'b1; ld_data = 32'hDEAD_BEEF;
        repeat (3) begin
            @(negedge clk);
            check("t4_extra_refused", 32'(ld_ready), 32'd0);
            tick();
        end
        ld_valid = 1'b0;
        wait_done(100, w);
        mism = 0;
        for (int i = 0; i < 64; i++) if (t_imem[i] !== s_prog[i]) mism++;
        check("t4_imem_all_words", 32'(mism), 32'd0);
        check("t4_cycles", 32'(cycles), 32'd65);

        // reset during RUN; a start pulse in RUN must be ignored
        for (int i = 0; i < 64; i++) s_prog[i] = '0;
        s_n = 4;
        run_test(32'h0, 32'h0, 0, 1'b1);
        repeat (5) tick();
        chk_addr = 32'h8; start = 1'b1;
        tick();
        start = 1'b0;
        repeat (5) tick();
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        @(negedge clk);
        check("t5_cpu_rst_n", 32'(cpu_rst_n), 32'd0);
        check("t5_done", 32'(done), 32'd0);
        check("t5_cycles", 32'(cycles), 32'd0);
        check("t5_busy", 32'(busy), 32'd0);

        for (int t = 0; t < 12; t++) begin
            logic [31:0] last_imm;
            int          last_idx;
            int          tgt;
            last_imm = '0; last_idx = 0;
            for (int i = 0; i < 64; i++) s_prog[i] = '0;
            s_n = $urandom_range(2, 16);
            for (int i = 0; i < s_n - 1; i++) begin
                case ($urandom_range(0, 3))
                    0: s_prog[i] = '0;
                    1, 2: begin
                        last_imm = 32'($urandom_range(0, 65535));
                        last_idx = $urandom_range(0, 3);
                        s_prog[i] = {2'b01, 8'h0, 6'(last_idx), last_imm[15:0]};
                    end
                    default: begin
                        tgt = $urandom_range(i + 1, s_n - 1);
                        s_prog[i] = {2'b10, 24'h0, 6'(tgt)};
                    end
                endcase
            end
            s_prog[s_n - 1] = ($urandom_range(0, 3) == 0) ? 32'h0 : {2'b10, 24'h0, 6'(s_n - 1)};
            run_test({26'h0, 6'(last_idx << 2)},
                     ($urandom_range(0, 3) == 0) ? $urandom : last_imm,
                     $urandom_range(0, 2), 1'b1);
            wait_done(MAXC + 20, w);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
